// File: rtl/f_predictpc.sv
// Direct-mapped BTB next-PC predictor with 2-bit branch counters and combinational lookup.
// Optional statistics outputs stat_ctrl/stat_miss are enabled by defining F_PREDICTPC_STATS_EN.
module f_predictpc #(
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetch_pc,
  output logic [31:0] pc_predicted,
  output logic        cannot_predict,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [1:0]  upd_jump_code,
  input  logic [31:0] upd_nextpc,
  input  logic        upd_fail
`ifdef F_PREDICTPC_STATS_EN
  ,
  output logic [31:0] stat_ctrl,
  output logic [31:0] stat_miss
`endif
);

  localparam int unsigned IW = $clog2(BTB_ENTRIES);
  localparam int unsigned TW = 30 - IW;

  typedef enum logic [1:0] {
    J_NONE = 2'b00,
    J_BR   = 2'b01,
    J_JAL  = 2'b10,
    J_JALR = 2'b11
  } jump_e;

  logic          r_valid  [BTB_ENTRIES];
  logic [1:0]    r_ctr    [BTB_ENTRIES];
  logic [TW-1:0] r_tag    [BTB_ENTRIES];
  logic [31:0]   r_target [BTB_ENTRIES];
  jump_e         r_type   [BTB_ENTRIES];

  logic [IW-1:0] w_fidx;
  logic [TW-1:0] w_ftag;
  logic          w_fhit;
  logic [IW-1:0] w_uidx;
  logic [TW-1:0] w_utag;
  logic          w_uhit;
  logic          w_taken;
  logic          w_ctrl;
  logic          w_alloc;
  logic          w_wr_ctr;
  logic          w_wr_tgt;
  logic [1:0]    w_ctr_nxt;
  jump_e         w_type_nxt;

  assign w_fidx = fetch_pc[IW+1:2];
  assign w_ftag = fetch_pc[31:IW+2];
  assign w_fhit = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);

  always_comb begin
    pc_predicted   = fetch_pc + 32'd4;
    cannot_predict = 1'b0;
    if (w_fhit) begin
      case (r_type[w_fidx])
        J_JAL:   pc_predicted = r_target[w_fidx];
        J_BR:    if (r_ctr[w_fidx][1]) pc_predicted = r_target[w_fidx];
        J_JALR:  cannot_predict = 1'b1;
        default: ;
      endcase
    end
  end

  assign w_uidx  = upd_pc[IW+1:2];
  assign w_utag  = upd_pc[31:IW+2];
  assign w_uhit  = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_taken = (upd_nextpc != (upd_pc + 32'd4));
  assign w_ctrl  = upd_valid && (jump_e'(upd_jump_code) != J_NONE);

  // A branch that hits only trains the counter (and target when taken); allocation rewrites the whole entry.
  always_comb begin
    w_alloc    = 1'b0;
    w_wr_ctr   = 1'b0;
    w_wr_tgt   = 1'b0;
    w_ctr_nxt  = 2'b11;
    w_type_nxt = jump_e'(upd_jump_code);
    if (w_ctrl) begin
      case (jump_e'(upd_jump_code))
        J_BR: begin
          if (w_uhit) begin
            w_wr_ctr = 1'b1;
            if (w_taken) begin
              w_wr_tgt  = 1'b1;
              w_ctr_nxt = (r_ctr[w_uidx] == 2'b11) ? 2'b11 : r_ctr[w_uidx] + 2'd1;
            end else begin
              w_ctr_nxt = (r_ctr[w_uidx] == 2'b00) ? 2'b00 : r_ctr[w_uidx] - 2'd1;
            end
          end else if (w_taken) begin
            w_alloc   = 1'b1;
            w_wr_ctr  = 1'b1;
            w_wr_tgt  = 1'b1;
            w_ctr_nxt = 2'b10;
          end
        end
        J_JAL, J_JALR: begin
          w_alloc   = 1'b1;
          w_wr_ctr  = 1'b1;
          w_wr_tgt  = 1'b1;
          w_ctr_nxt = 2'b11;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b01;
      end
    end else begin
      if (w_alloc)  r_valid[w_uidx] <= 1'b1;
      if (w_wr_ctr) r_ctr[w_uidx]   <= w_ctr_nxt;
    end
  end

  // Payload fields carry no reset; a cleared valid bit masks them.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_tag[w_uidx]  <= w_utag;
      r_type[w_uidx] <= w_type_nxt;
    end
    if (w_wr_tgt) r_target[w_uidx] <= upd_nextpc;
  end

`ifdef F_PREDICTPC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ctrl <= '0;
      stat_miss <= '0;
    end else if (w_ctrl) begin
      stat_ctrl <= stat_ctrl + 32'd1;
      if (upd_fail) stat_miss <= stat_miss + 32'd1;
    end
  end
`else
  logic w_unused_fail;
  assign w_unused_fail = upd_fail;
`endif

endmodule

// File: tb/tb_f_predictpc.sv
// Randomized bench for f_predictpc against a table-level BTB model; define F_PREDICTPC_STATS_EN to cover the statistics outputs.
module tb_f_predictpc;

  localparam int unsigned N = 16;

  logic        clk;
  logic        rst_n;
  logic [31:0] fetch_pc;
  logic [31:0] pc_predicted;
  logic        cannot_predict;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [1:0]  upd_jump_code;
  logic [31:0] upd_nextpc;
  logic        upd_fail;
`ifdef F_PREDICTPC_STATS_EN
  logic [31:0] stat_ctrl;
  logic [31:0] stat_miss;
`endif

  f_predictpc #(.BTB_ENTRIES(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_pc      (fetch_pc),
    .pc_predicted  (pc_predicted),
    .cannot_predict(cannot_predict),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_jump_code (upd_jump_code),
    .upd_nextpc    (upd_nextpc),
    .upd_fail      (upd_fail)
`ifdef F_PREDICTPC_STATS_EN
    ,
    .stat_ctrl     (stat_ctrl),
    .stat_miss     (stat_miss)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference table: one record per slot, keyed by (pc/4) mod N, tagged by pc / (4N).
  bit          m_valid [N];
  int unsigned m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_kind  [N];   // 1 branch, 2 jal, 3 jalr
  int          m_cnt   [N];
  logic [31:0] m_stat_ctrl;
  logic [31:0] m_stat_miss;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < int'(N); i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 1;
    end
    m_stat_ctrl = 32'd0;
    m_stat_miss = 32'd0;
  endfunction

  function automatic void model_predict(input logic [31:0] pc, output logic [31:0] e_pc, output logic e_cp);
    int          idx;
    int unsigned tag;
    idx  = int'((pc / 4) % N);
    tag  = pc / (N * 4);
    e_pc = pc + 32'd4;
    e_cp = 1'b0;
    if (m_valid[idx] && m_tag[idx] == tag) begin
      if (m_kind[idx] == 2) e_pc = m_tgt[idx];
      else if (m_kind[idx] == 1 && m_cnt[idx] >= 2) e_pc = m_tgt[idx];
      else if (m_kind[idx] == 3) e_cp = 1'b1;
    end
  endfunction

  function automatic void model_update(input logic [31:0] pc, input logic [1:0] code,
                                       input logic [31:0] npc, input logic fail);
    int          idx;
    int unsigned tag;
    bit          hit;
    bit          taken;
    if (code == 2'b00) return;
    m_stat_ctrl = m_stat_ctrl + 32'd1;
    if (fail) m_stat_miss = m_stat_miss + 32'd1;
    idx   = int'((pc / 4) % N);
    tag   = pc / (N * 4);
    hit   = m_valid[idx] && m_tag[idx] == tag;
    taken = (npc != pc + 32'd4);
    if (code == 2'b01) begin
      if (hit) begin
        if (taken) begin
          m_cnt[idx] = (m_cnt[idx] < 3) ? m_cnt[idx] + 1 : 3;
          m_tgt[idx] = npc;
        end else begin
          m_cnt[idx] = (m_cnt[idx] > 0) ? m_cnt[idx] - 1 : 0;
        end
      end else if (taken) begin
        m_valid[idx] = 1'b1; m_tag[idx] = tag; m_tgt[idx] = npc; m_kind[idx] = 1; m_cnt[idx] = 2;
      end
    end else begin
      m_valid[idx] = 1'b1; m_tag[idx] = tag; m_tgt[idx] = npc; m_kind[idx] = int'(code); m_cnt[idx] = 3;
    end
  endfunction

  task automatic check_outputs(input string tag);
    logic [31:0] e_pc;
    logic        e_cp;
    model_predict(fetch_pc, e_pc, e_cp);
    check({tag, ".pc"}, pc_predicted, e_pc);
    check({tag, ".cp"}, {31'd0, cannot_predict}, {31'd0, e_cp});
`ifdef F_PREDICTPC_STATS_EN
    check({tag, ".sctrl"}, stat_ctrl, m_stat_ctrl);
    check({tag, ".smiss"}, stat_miss, m_stat_miss);
`endif
  endtask

  // One clock: drive at the falling edge, check the pre-update lookup, then retire the update.
  task automatic cycle(input string tag, input logic rst_in, input logic uv, input logic [31:0] upc,
                       input logic [1:0] code, input logic [31:0] unpc, input logic ufail,
                       input logic [31:0] fpc);
    @(negedge clk);
    rst_n         = rst_in;
    upd_valid     = uv;
    upd_pc        = upc;
    upd_jump_code = code;
    upd_nextpc    = unpc;
    upd_fail      = ufail;
    fetch_pc      = fpc;
    if (!rst_in) model_reset();
    #1;
    check_outputs(tag);
    @(posedge clk);
    if (rst_in && uv) model_update(upc, code, unpc, ufail);
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] fpc;
    rst_n = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_jump_code = 2'b00;
    upd_nextpc = '0; upd_fail = 1'b0; fetch_pc = 32'h100;
    model_reset();

    cycle("rst_hold",   1'b0, 1'b0, 32'h0,       2'b00, 32'h0,   1'b0, 32'h100);
    cycle("rel_upd",    1'b1, 1'b1, 32'h100,     2'b01, 32'h140, 1'b0, 32'h100);
    cycle("br_taken",   1'b1, 1'b1, 32'h100,     2'b01, 32'h104, 1'b0, 32'h100);
    cycle("br_nt1",     1'b1, 1'b1, 32'h100,     2'b01, 32'h104, 1'b1, 32'h100);
    cycle("jalr_upd",   1'b1, 1'b1, 32'h200,     2'b11, 32'h0,   1'b0, 32'h100);
    cycle("jalr_hit",   1'b1, 1'b1, 32'h200+N*4, 2'b10, 32'h80,  1'b1, 32'h200);
    cycle("alias_miss", 1'b1, 1'b0, 32'h0,       2'b00, 32'h0,   1'b0, 32'h200);
    cycle("jal_alias",  1'b1, 1'b0, 32'h0,       2'b00, 32'h0,   1'b0, 32'h200+N*4);
    cycle("wrap",       1'b1, 1'b0, 32'h0,       2'b00, 32'h0,   1'b0, 32'hFFFF_FFFC);
    cycle("same_cyc",   1'b1, 1'b1, 32'h300,     2'b10, 32'h400, 1'b0, 32'h300);
    cycle("jal_next",   1'b1, 1'b1, 32'h300,     2'b00, 32'h500, 1'b1, 32'h300);
    cycle("code00",     1'b1, 1'b1, 32'h400,     2'b01, 32'h480, 1'b0, 32'h300);

    // Reset mid-cycle, with no clock edge in between: learned entries vanish at once.
    @(negedge clk);
    upd_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    cycle("rst_clk",    1'b0, 1'b1, 32'h300,     2'b10, 32'h400, 1'b1, 32'h300);
    cycle("rst_rel",    1'b1, 1'b0, 32'h0,       2'b00, 32'h0,   1'b0, 32'h400);

    for (int i = 0; i < 600; i++) begin
      pc  = ($urandom_range(0, 2) * N + $urandom_range(0, N - 1)) * 4;
      if (i % 97 == 50) pc = 32'hFFFF_FFFC;
      npc = ($urandom_range(0, 1) == 0) ? pc + 32'd4 : {$urandom_range(0, 1023), 2'b00};
      fpc = ($urandom_range(0, 2) * N + $urandom_range(0, N - 1)) * 4;
      if (i % 5 == 0) fpc = pc;
      cycle("rand", (i % 150) != 149, $urandom_range(0, 4) != 0, pc,
            2'($urandom_range(0, 3)), npc, 1'($urandom_range(0, 1)), fpc);
    end

    cycle("tail",       1'b1, 1'b0, 32'h0,       2'b00, 32'h0,   1'b0, 32'h100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/f_predictpc.md
F_PREDICTPC -- requirements
Module: f_predictpc

Interface
REQ-001 SHALL have parameter BTB_ENTRIES, default 16, meaning the number of direct-mapped BTB entries; legal values are powers of two from 4 to 64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port fetch_pc, input, 32 bits: PC of the instruction being fetched this cycle.
REQ-005 SHALL have port pc_predicted, output, 32 bits: predicted next PC for fetch_pc.
REQ-006 SHALL have port cannot_predict, output, 1 bit: target is not predictable, so fetch holds until decode resolves it.
REQ-007 SHALL have port upd_valid, input, 1 bit: the decode-stage resolution below is valid this cycle.
REQ-008 SHALL have port upd_pc, input, 32 bits: PC of the resolved instruction.
REQ-009 SHALL have port upd_jump_code, input, 2 bits: 11=JALR, 10=JAL, 01=conditional branch, 00=non-control.
REQ-010 SHALL have port upd_nextpc, input, 32 bits: resolved next PC from decode.
REQ-011 SHALL have port upd_fail, input, 1 bit: decode flagged a misprediction for upd_pc.

Function
REQ-012 SHALL index the BTB with fetch_pc[IW+1:2], where IW=log2(BTB_ENTRIES), and SHALL tag with fetch_pc[31:IW+2].
REQ-013 Each entry SHALL hold: valid bit, tag, 32-bit target, 2-bit type (same encoding as upd_jump_code), and a 2-bit saturating counter.
REQ-014 Lookup SHALL be combinational, with zero-cycle latency from fetch_pc to pc_predicted and cannot_predict.
REQ-015 A hit SHALL require a valid entry whose tag matches fetch_pc.
REQ-016 pc_predicted SHALL be the entry target on a hit of type JAL, and on a hit of type branch with counter[1]=1.
REQ-017 In every other case, pc_predicted SHALL be fetch_pc+4, computed modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-018 cannot_predict SHALL be 1 only on a hit of type JALR; in that case pc_predicted SHALL be fetch_pc+4.
REQ-019 The resolution SHALL be counted as taken when upd_nextpc != upd_pc+4 (32-bit compare).
REQ-020 An update SHALL write only at the clock edge in a cycle with upd_valid=1 and upd_jump_code!=00; upd_jump_code=00 SHALL leave the BTB unchanged.
REQ-021 Branch, hit, taken: counter SHALL increment, saturating at 11, and target SHALL become upd_nextpc.
REQ-022 Branch, hit, not taken: counter SHALL decrement, saturating at 00; target SHALL be unchanged.
REQ-023 Branch, miss, taken: the entry SHALL be allocated (overwriting any prior content) with valid=1, new tag, target=upd_nextpc, type=01, counter=10.
REQ-024 Branch, miss, not taken: the BTB SHALL be unchanged.
REQ-025 JAL: the entry SHALL be allocated or overwritten with type=10, target=upd_nextpc, counter=11.
REQ-026 JALR: the entry SHALL be allocated or overwritten with type=11 and counter=11; the target field is don't-care.
REQ-027 When a lookup and an update hit the same index in the same cycle, the lookup SHALL see the pre-update contents (no bypass); the new contents are visible from the next cycle.
REQ-028 upd_fail SHALL NOT alter the update rules; it is used only by the statistics feature (REQ-034).

Reset
REQ-029 While rst_n=0, all valid bits SHALL be 0 and all counters SHALL be 01, asynchronously and regardless of clk.
REQ-030 Tag, target and type fields SHALL need no reset.
REQ-031 During and after reset, before any update, outputs SHALL be pc_predicted=fetch_pc+4 and cannot_predict=0.
REQ-032 An update presented in the same cycle that rst_n deasserts SHALL be captured at the next rising edge.
REQ-033 Reset asserted mid-operation SHALL discard all learned entries immediately.

Configuration
REQ-034 With macro F_PREDICTPC_STATS_EN defined, the block SHALL add two 32-bit outputs, stat_ctrl and stat_miss.
- stat_ctrl SHALL increment on each cycle with upd_valid=1 and upd_jump_code!=00.
- stat_miss SHALL increment on such cycles that also have upd_fail=1.
- Both SHALL reset to 0, wrap modulo 2^32, and are otherwise unaffected by reset of the BTB.
REQ-035 Without F_PREDICTPC_STATS_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-036 Reset, then fetch_pc=0x00000100 -> pc_predicted=0x00000104, cannot_predict=0.
REQ-037 Update upd_pc=0x100, code=01, nextpc=0x140 -> next cycle fetch_pc=0x100 gives pc_predicted=0x140.
- Then two not-taken updates (nextpc=0x104) -> pc_predicted=0x104.
REQ-038 Update upd_pc=0x200, code=11 -> fetch_pc=0x200 gives cannot_predict=1, pc_predicted=0x204.
- Then update upd_pc=0x200+BTB_ENTRIES*4 (same index, different tag), code=10, nextpc=0x80 -> fetch_pc=0x200 gives cannot_predict=0, pc_predicted=0x204.
REQ-039 fetch_pc=0xFFFFFFFC with an empty BTB -> pc_predicted=0x00000000.
REQ-040 Same-cycle lookup and JAL update at fetch_pc=upd_pc=0x300, nextpc=0x400 -> that cycle pc_predicted=0x304; next cycle pc_predicted=0x400.
REQ-041 With F_PREDICTPC_STATS_EN defined: 5 control updates, 2 of them with upd_fail=1 -> stat_ctrl=5, stat_miss=2; rst_n pulse -> both 0.
